// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD init/refresh sequencer: FSM states,
// HD44780 command bytes, sequence index bounds and index decode helpers.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_DELAY,
    ST_IDLE
  } lcd_state_e;

  // Initialisation commands: 8-bit/2-line, display on, clear, entry mode
  localparam logic [7:0] LCD_CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_CMD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_LINE1_ADDR   = 8'h80;
  localparam logic [7:0] LCD_LINE2_ADDR   = 8'hC0;

  // Sequence index bounds
  localparam logic [5:0] IDX_REFRESH = 6'd5;   // line-1 address command, refresh entry
  localparam logic [5:0] IDX_LINE2   = 6'd22;  // line-2 address command
  localparam logic [5:0] IDX_LAST    = 6'd38;  // final character of line 2

  // Offsets from idx to character buffer address on each line
  localparam logic [5:0] CHAR_OFS_L1 = 6'd6;
  localparam logic [5:0] CHAR_OFS_L2 = 6'd7;

  function automatic logic idx_is_data(input logic [5:0] idx);
    return ((idx > IDX_REFRESH) && (idx < IDX_LINE2)) ||
           ((idx > IDX_LINE2) && (idx <= IDX_LAST));
  endfunction

  function automatic logic [7:0] idx_cmd(input logic [5:0] idx);
    logic [7:0] cmd;
    case (idx)
      6'd0:        cmd = LCD_CMD_FUNC_SET;
      6'd1:        cmd = LCD_CMD_DISP_ON;
      6'd2:        cmd = LCD_CMD_CLEAR;
      6'd3:        cmd = LCD_CMD_ENTRY;
      6'd4:        cmd = LCD_LINE1_ADDR;
      IDX_REFRESH: cmd = LCD_LINE1_ADDR;
      IDX_LINE2:   cmd = LCD_LINE2_ADDR;
      default:     cmd = 8'h00;
    endcase
    return cmd;
  endfunction

  function automatic logic [4:0] idx_char_addr(input logic [5:0] idx);
    logic [5:0] ofs;
    ofs = 6'd0;
    if ((idx > IDX_REFRESH) && (idx < IDX_LINE2)) begin
      ofs = idx - CHAR_OFS_L1;
    end else if ((idx > IDX_LINE2) && (idx <= IDX_LAST)) begin
      ofs = idx - CHAR_OFS_L2;
    end
    return ofs[4:0];
  endfunction

endpackage

// File: rtl/lcd_init_sequencer_if.sv
// Byte handshake between the sequencer (master) and the single-transfer
// LCD write-strobe controller (slave).
interface lcd_init_sequencer_if;
  logic [7:0] oLCD_DATA;
  logic       oLCD_RS;
  logic       oLCD_START;
  logic       iLCD_DONE;

  modport master (output oLCD_DATA, output oLCD_RS, output oLCD_START, input iLCD_DONE);
  modport slave  (input oLCD_DATA, input oLCD_RS, input oLCD_START, output iLCD_DONE);
endinterface

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter used for power-up wait, inter-transfer delay and
// the optional auto-refresh gap. Holds at zero; expired is high at zero.
module lcd_delay_counter #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise decrement until zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Count register; reset value starts the power-up wait immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= RST_VAL;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/lcd_init_sequencer.sv
// HD44780 16x2 init + character-pass sequencer. Orders commands/data and
// owns all inter-transfer delays; the downstream controller only strobes EN.
// Optional build macro LCD_SEQ_AUTO_REFRESH_EN: when defined, IDLE waits
// DLY_CYCLES and then self-triggers another character pass.
module lcd_init_sequencer
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYCLES = 1_000_000,
  parameter int DLY_CYCLES   = 250_000
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic                 iREFRESH,
  output logic [4:0]           oCHAR_ADDR,
  input  logic [7:0]           iCHAR,
  output logic                 oBUSY,
  lcd_init_sequencer_if.master lcd
);

  localparam int MAX_CYCLES = (PWRUP_CYCLES > DLY_CYCLES) ? PWRUP_CYCLES : DLY_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  // Counter expires after (load value + 1) cycles, hence the -1
  localparam logic [CNT_W-1:0] PWRUP_LOAD = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LOAD   = CNT_W'(DLY_CYCLES - 1);
  // Stale-done mask length in WAIT
  localparam logic [1:0]       GUARD_LAST = 2'd2;

  lcd_state_e state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       rs_q, rs_d;
  logic       start_q, start_d;
  logic [1:0] guard_q, guard_d;
  logic       pending_q, pending_d;
  logic       busy_q, busy_d;
  logic       cnt_load;
  logic       cnt_expired;
  logic       auto_fire;

  lcd_delay_counter #(
    .WIDTH   (CNT_W),
    .RST_VAL (PWRUP_LOAD)
  ) u_delay (
    .clk      (iCLK),
    .rst_n    (iRST_N),
    .load     (cnt_load),
    .load_val (DLY_LOAD),
    .expired  (cnt_expired)
  );

`ifdef LCD_SEQ_AUTO_REFRESH_EN
  assign auto_fire = cnt_expired;
`else
  assign auto_fire = 1'b0;
`endif

  // Next-state, index, output-register and pending-flag logic
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    rs_d      = rs_q;
    start_d   = start_q;
    guard_d   = guard_q;
    pending_d = pending_q;
    cnt_load  = 1'b0;

    if (iREFRESH && (state_q != ST_IDLE)) pending_d = 1'b1;

    case (state_q)
      ST_PWRUP: begin
        if (cnt_expired) begin
          idx_d   = 6'd0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        rs_d    = idx_is_data(idx_q);
        data_d  = idx_is_data(idx_q) ? iCHAR : idx_cmd(idx_q);
        state_d = ST_START;
      end
      ST_START: begin
        start_d = 1'b1;
        guard_d = 2'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Done may still be high from the previous byte; ignore it briefly
        if (guard_q != GUARD_LAST) begin
          guard_d = guard_q + 2'd1;
        end else if (lcd.iLCD_DONE) begin
          start_d  = 1'b0;
          idx_d    = idx_q + 6'd1;
          cnt_load = 1'b1;
          state_d  = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (cnt_expired) begin
          if (idx_q <= IDX_LAST) begin
            state_d = ST_LOAD;
          end else if (pending_q || iREFRESH) begin
            // Queued refresh runs straight on, keeping busy high
            pending_d = 1'b0;
            idx_d     = IDX_REFRESH;
            state_d   = ST_LOAD;
          end else begin
            cnt_load = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_IDLE: begin
        if (iREFRESH || auto_fire) begin
          idx_d   = IDX_REFRESH;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_PWRUP;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= ST_PWRUP;
      idx_q     <= 6'd0;
      data_q    <= 8'h00;
      rs_q      <= 1'b0;
      start_q   <= 1'b0;
      guard_q   <= 2'd0;
      pending_q <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      rs_q      <= rs_d;
      start_q   <= start_d;
      guard_q   <= guard_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
    end
  end

  assign oCHAR_ADDR     = idx_char_addr(idx_q);
  assign oBUSY          = busy_q;
  assign lcd.oLCD_DATA  = data_q;
  assign lcd.oLCD_RS    = rs_q;
  assign lcd.oLCD_START = start_q;

endmodule

// File: doc/lcd_init_sequencer.md
# lcd_init_sequencer

Command/data sequencer driving the single-transfer LCD write-strobe controller (HD44780-class, 16x2, 8-bit, write-only). After power-up it waits, issues a fixed five-command initialisation, then writes 32 characters from an external character buffer across both display lines. It re-runs the character pass on request. It owns all ordering and inter-command delay; the downstream controller only generates the EN pulse for one byte.

## Interface
- `PWRUP_CYCLES`, 1_000_000: idle cycles after reset before the first command (20 ms at 50 MHz).
- `DLY_CYCLES`, 250_000: gap after each completed transfer; must be ≥ 2.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `iCLK` in 1: system clock.
- `iRST_N` in 1: asynchronous active-low reset.
- `iREFRESH` in 1: single-cycle pulse requesting a rewrite of the 32 characters.
- `oCHAR_ADDR` out 5: character buffer read address (0–15 line 1, 16–31 line 2).
- `iCHAR` in 8: character code at `oCHAR_ADDR`; buffer read latency ≤ `DLY_CYCLES`-1.
- `oLCD_DATA` out 8: byte to the controller.
- `oLCD_RS` out 1: 0 = command, 1 = data.
- `oLCD_START` out 1: transfer request; the controller acts on its rising edge.
- `iLCD_DONE` in 1: controller completion flag. It is level-held high after completion and cleared by the controller one cycle after it samples a new start edge.
- `oBUSY` out 1: high while any pass is in progress or pending.

## Operation
- Sequence index `idx`, 6 bits, range 0..38.
  - 0..4: commands 0x38, 0x0C, 0x01, 0x06, 0x80.
  - 5: command 0x80.
  - 6..21: data, characters 0..15.
  - 22: command 0xC0.
  - 23..38: data, characters 16..31.
- `oCHAR_ADDR` is combinational from `idx`:
  - `idx`-6 for 6..21.
  - `idx`-7 for 23..38.
  - 0 otherwise.
- States:
  - PWRUP: count `PWRUP_CYCLES`, then go to LOAD with `idx`=0.
  - LOAD: register `oLCD_DATA`/`oLCD_RS` (command constant, or `iCHAR`), then go to START.
  - START: assert `oLCD_START`. Clear a 2-bit guard counter. Go to WAIT.
  - WAIT: hold `oLCD_START` high. Ignore `iLCD_DONE` for the first 2 cycles, which masks the stale done from the previous transfer. Then on `iLCD_DONE`=1, drop `oLCD_START` and go to DELAY.
  - DELAY: `idx` increments on entry; count `DLY_CYCLES`. On expiry:
    - if `idx` ≤ 38, go to LOAD;
    - else go to IDLE.
  - IDLE: `oBUSY`=0. On `iREFRESH`, set `idx`=5 and go to LOAD.
- `oLCD_DATA`/`oLCD_RS` are stable from LOAD exit until DELAY exit. The controller passes them straight to the pins.
- `iREFRESH` outside IDLE sets a pending flag.
  - The flag is consumed on the DELAY→IDLE transition, which goes instead to LOAD with `idx`=5.
  - Multiple pulses merge into one.
- An `iREFRESH` pulse coincident with IDLE entry counts as pending and is not lost.
- Init commands (0..4) run only after reset; a refresh never reissues them.
- Reset mid-transfer forces PWRUP and a full init. The controller shares the reset.

## Timing
- Reset values:
  - `oLCD_DATA`=0x00, `oLCD_RS`=0, `oLCD_START`=0, `oBUSY`=1, `oCHAR_ADDR`=0.
  - Internal state PWRUP, `idx`=0, pending=0.
- All outputs are registered except `oCHAR_ADDR`.
- First `oLCD_START` rise: `PWRUP_CYCLES`+2 cycles after reset release.
- Per transfer: START→done = controller latency + ≥2 guard cycles.
- Start falls the cycle after done is sampled, followed by exactly `DLY_CYCLES` cycles of DELAY.
- LOAD samples `iCHAR` ≥ `DLY_CYCLES` cycles after `oCHAR_ADDR` changed.
- Full refresh = 34 transfers. Boot = 39 transfers.

## Configuration
- `LCD_SEQ_AUTO_REFRESH_EN`
  - Defined: IDLE counts `DLY_CYCLES` and then self-triggers a refresh, giving continuous rewriting. `oBUSY` still drops to 0 during the IDLE gap. `iREFRESH` is still honoured.
  - Undefined: the pass runs only on `iREFRESH`. IDLE waits indefinitely.

## Structure
- Shared package `lcd_pkg`:
  - state enum;
  - init command constants;
  - `LCD_LINE1_ADDR`=0x80, `LCD_LINE2_ADDR`=0xC0;
  - index bounds (`IDX_REFRESH`=5, `IDX_LINE2`=22, `IDX_LAST`=38).
- Sub-module `lcd_delay_counter`:
  - loadable down-counter, width $clog2(max(PWRUP_CYCLES, DLY_CYCLES))+1;
  - `load`/`expired` interface;
  - used for PWRUP, DELAY and auto-refresh IDLE.

## Test plan
Bench uses `PWRUP_CYCLES`=8, `DLY_CYCLES`=4, real controller with divide 2, and a buffer model holding 0x41+addr.
- Reset, then release → first start rises at cycle 10. Bytes are 0x38, 0x0C, 0x01, 0x06, 0x80 with RS=0. Then 0x80, 0x41..0x50 (RS=1), 0xC0, 0x51..0x60. `oBUSY` falls after byte 39.
- Check every EN-high window → `oLCD_DATA`/`oLCD_RS` constant. No start edge while done is stale-high is missed or double-counted.
- In IDLE, pulse `iREFRESH` → 34 transfers starting at 0x80. No 0x38..0x06 commands.
- `iREFRESH` pulsed 3 times during the boot pass → exactly one extra refresh pass follows, with `oBUSY` held high throughout.
- Reset asserted during the 20th transfer's WAIT → outputs return to reset values asynchronously. The full 39-byte boot sequence repeats.
- With `LCD_SEQ_AUTO_REFRESH_EN` and no `iREFRESH` → passes repeat, each starting at 0x80, separated by 4 IDLE plus 4 DELAY cycles.
